// File: rtl/mlp_inference_scheduler.sv
// Single-frame sequencer for the MLP jet tagger: launch, wait for done, settle softmax, argmax, present.
// One frame in flight; s_ready only in IDLE, result held on m_* until m_ready.
module mlp_inference_scheduler #(
    parameter int WIDTH         = 16,
    parameter int NFRAC         = 10,
    parameter int INPUT_SIZE    = 16,
    parameter int OUTPUT_SIZE   = 5,
    parameter int SOFTMAX_DELAY = 2,
    parameter int TIMEOUT       = 1024,
    parameter int LAT_W         = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [WIDTH*INPUT_SIZE-1:0]        s_data,
    output logic                               net_input_ready,
    output logic [WIDTH*INPUT_SIZE-1:0]        net_input_data,
    input  logic                               net_output_ready,
    input  logic [WIDTH*OUTPUT_SIZE-1:0]       net_output_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic [WIDTH*OUTPUT_SIZE-1:0]       m_data,
    output logic [$clog2(OUTPUT_SIZE)-1:0]     m_class,
    output logic                               busy,
    output logic                               timeout_err,
    output logic [LAT_W-1:0]                   frame_count,
    output logic [LAT_W-1:0]                   last_latency
);
    localparam int CLS_W = $clog2(OUTPUT_SIZE);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = (SOFTMAX_DELAY > 1) ? $clog2(SOFTMAX_DELAY) : 1;
    localparam longint unsigned LAT_MAX = (64'd1 << LAT_W) - 64'd1;

    // Scores carry NFRAC fractional bits but are only compared, so the point must sit inside the word.
    if (NFRAC >= WIDTH || OUTPUT_SIZE < 2) begin : g_param_check
        $error("mlp_inference_scheduler: unsupported NFRAC/OUTPUT_SIZE");
    end

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_SETTLE, S_ARGMAX, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH*INPUT_SIZE-1:0] feat_q;
    logic signed [WIDTH-1:0]   scores_q [OUTPUT_SIZE];
    logic [CNT_W-1:0]          cnt_q, cnt_inc;
    logic [SET_W-1:0]          settle_q;
    logic [CLS_W-1:0]          idx_q, best_q, best_next, class_q;
    logic [LAT_W-1:0]          frame_q, lat_q, lat_sat;
    logic                      tmo_q;
    logic                      accept, wait_done, wait_tmo, settle_last, capture, argmax_last;

    assign accept      = s_valid && (state_q == S_IDLE);
    assign wait_done   = (state_q == S_WAIT) && net_output_ready;
    assign wait_tmo    = (state_q == S_WAIT) && !net_output_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign settle_last = (state_q == S_SETTLE) && (settle_q == SET_W'(SOFTMAX_DELAY - 1));
    assign capture     = (SOFTMAX_DELAY == 0) ? wait_done : settle_last;
    assign argmax_last = (state_q == S_ARGMAX) && (idx_q == CLS_W'(OUTPUT_SIZE - 1));
    assign cnt_inc     = cnt_q + 1'b1;
    // Strict greater-than keeps the lower index on ties.
    assign best_next   = (scores_q[idx_q] > scores_q[best_q]) ? idx_q : best_q;

    always_comb begin
        lat_sat = LAT_W'(cnt_inc);
        if (64'(cnt_inc) > LAT_MAX) lat_sat = '1;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (net_output_ready) state_d = (SOFTMAX_DELAY == 0) ? S_ARGMAX : S_SETTLE;
                else if (wait_tmo)    state_d = S_IDLE;
            end
            S_SETTLE: if (settle_last) state_d = S_ARGMAX;
            S_ARGMAX: if (argmax_last) state_d = S_OUT;
            S_OUT:    if (m_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_ready         = (state_q == S_IDLE);
        net_input_ready = (state_q == S_LAUNCH);
        m_valid         = (state_q == S_OUT);
        busy            = (state_q != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            feat_q   <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            idx_q    <= '0;
            best_q   <= '0;
            class_q  <= '0;
            frame_q  <= '0;
            lat_q    <= '0;
            tmo_q    <= 1'b0;
            for (int k = 0; k < OUTPUT_SIZE; k++) scores_q[k] <= '0;
        end else begin
            if (accept) feat_q <= s_data;
            if (state_q == S_LAUNCH)    cnt_q <= '0;
            else if (state_q == S_WAIT) cnt_q <= cnt_inc;
            if (wait_done) lat_q <= lat_sat;
            if (wait_tmo)  tmo_q <= 1'b1;
            if (state_q == S_WAIT)        settle_q <= '0;
            else if (state_q == S_SETTLE) settle_q <= settle_q + 1'b1;
            if (capture) begin
                for (int k = 0; k < OUTPUT_SIZE; k++)
                    scores_q[k] <= net_output_data[k*WIDTH +: WIDTH];
                best_q <= '0;
                idx_q  <= CLS_W'(1);
            end
            if (state_q == S_ARGMAX) begin
                best_q <= best_next;
                idx_q  <= idx_q + 1'b1;
                if (argmax_last) class_q <= best_next;
            end
            if ((state_q == S_OUT) && m_ready) frame_q <= frame_q + 1'b1;
        end
    end

    always_comb begin
        m_data = '0;
        for (int k = 0; k < OUTPUT_SIZE; k++) m_data[k*WIDTH +: WIDTH] = scores_q[k];
    end

    assign net_input_data = feat_q;
    assign m_class        = class_q;
    assign timeout_err    = tmo_q;
    assign frame_count    = frame_q;
    assign last_latency   = lat_q;
endmodule

// File: tb/tb_mlp_inference_scheduler.sv
// Directed bench for mlp_inference_scheduler with a behavioural network that raises done a set number of cycles after start.
module tb_mlp_inference_scheduler;
    localparam int W  = 16;
    localparam int IN = 16;
    localparam int NO = 5;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              s_valid = 1'b0;
    logic              m_ready = 1'b0;
    logic              net_done = 1'b0;
    logic [W*IN-1:0]   s_data = '0;
    logic [W*NO-1:0]   net_data = '0;

    logic              s_ready, net_input_ready, m_valid, busy, timeout_err;
    logic [W*IN-1:0]   net_input_data;
    logic [W*NO-1:0]   m_data;
    logic [CW-1:0]     m_class;
    logic [15:0]       frame_count, last_latency;

    int checks = 0;
    int fails = 0;
    int start_cnt = 0;
    int net_lat = 0;

    mlp_inference_scheduler dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .net_input_ready(net_input_ready), .net_input_data(net_input_data),
        .net_output_ready(net_done), .net_output_data(net_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_class(m_class),
        .busy(busy), .timeout_err(timeout_err),
        .frame_count(frame_count), .last_latency(last_latency)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (net_input_ready === 1'b1) start_cnt++;

    // Network: done pulses in the net_lat-th cycle after the start pulse; net_lat=0 never answers.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (net_input_ready === 1'b1 && net_lat != 0) begin
                repeat (net_lat) @(posedge clk);
                #1 net_done = 1'b1;
                @(posedge clk);
                #1 net_done = 1'b0;
            end
        end
    end

    task automatic set_scores(input int a, input int b, input int c, input int d, input int e);
        net_data = {W'(e), W'(d), W'(c), W'(b), W'(a)};
    endtask

    function automatic int ref_argmax(input logic [W*NO-1:0] d);
        int best = NO - 1;
        for (int i = NO - 2; i >= 0; i--)
            if ($signed(d[i*W +: W]) >= $signed(d[best*W +: W])) best = i;
        return best;
    endfunction

    // Returns one cycle after the accept cycle (i.e. in LAUNCH).
    task automatic send_frame(input logic [W*IN-1:0] f, output bit ok);
        ok = 1'b0;
        s_data = f;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (s_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_result(output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (m_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({s_ready, net_input_ready, m_valid, busy, timeout_err} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 10000", {s_ready, net_input_ready, m_valid, busy, timeout_err});
        end
        checks++;
        if (frame_count !== 16'd0 || last_latency !== 16'd0 || m_class !== 3'd0) begin
            fails++;
            $display("FAIL reset_counters: fc=%0d lat=%0d cls=%0d want 0", frame_count, last_latency, m_class);
        end
        checks++;
        if (m_data !== '0 || net_input_data !== '0) begin
            fails++;
            $display("FAIL reset_data: m_data=%h nid=%h want 0", m_data, net_input_data);
        end
    endtask

    task automatic test_basic();
        logic [W*IN-1:0] f;
        bit ok;
        int n, st;
        f = {IN{16'h0400}};
        m_ready = 1'b1;
        net_lat = 10;
        set_scores(100, -50, 300, 300, 20);
        st = start_cnt;
        send_frame(f, ok);
        checks++;
        if (!ok || net_input_data !== f) begin
            fails++;
            $display("FAIL basic_accept: ok=%0d nid=%h want %h", ok, net_input_data, f);
        end
        wait_result(n, ok);
        checks++;
        if (!ok || n + 1 != 18) begin
            fails++;
            $display("FAIL basic_latency: ok=%0d cycles=%0d want 18", ok, n + 1);
        end
        checks++;
        if (m_data !== net_data) begin
            fails++;
            $display("FAIL basic_mdata: got %h want %h", m_data, net_data);
        end
        checks++;
        if (m_class !== 3'd2) begin
            fails++;
            $display("FAIL basic_class: got %0d want 2", m_class);
        end
        checks++;
        if (last_latency !== 16'd10) begin
            fails++;
            $display("FAIL basic_last_latency: got %0d want 10", last_latency);
        end
        checks++;
        if (start_cnt - st != 1) begin
            fails++;
            $display("FAIL basic_starts: got %0d want 1", start_cnt - st);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_count !== 16'd1 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_handshake: fc=%0d mv=%b sr=%b want 1 0 1", frame_count, m_valid, s_ready);
        end
    endtask

    task automatic test_negative();
        bit ok;
        int n;
        m_ready = 1'b1;
        net_lat = 4;
        set_scores(-5, -3, -9, -3, -100);
        send_frame({IN{16'hFC00}}, ok);
        wait_result(n, ok);
        checks++;
        if (!ok || m_class !== 3'd1) begin
            fails++;
            $display("FAIL neg_class: ok=%0d got %0d want 1", ok, m_class);
        end
        checks++;
        if (last_latency !== 16'd4) begin
            fails++;
            $display("FAIL neg_last_latency: got %0d want 4", last_latency);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_count !== 16'd2) begin
            fails++;
            $display("FAIL neg_frame_count: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_timeout();
        bit ok, saw_mv;
        int n, st;
        m_ready = 1'b1;
        net_lat = 0;
        saw_mv = 1'b0;
        st = start_cnt;
        send_frame({IN{16'h0123}}, ok);
        repeat (1024) begin
            @(posedge clk); #1;
            if (m_valid === 1'b1) saw_mv = 1'b1;
        end
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL tmo_early: err=%b busy=%b want 0 1", timeout_err, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL tmo_abort: err=%b busy=%b sr=%b want 1 0 1", timeout_err, busy, s_ready);
        end
        checks++;
        if (saw_mv || frame_count !== 16'd2 || last_latency !== 16'd4 || start_cnt - st != 1) begin
            fails++;
            $display("FAIL tmo_side: mv=%0d fc=%0d lat=%0d starts=%0d want 0 2 4 1",
                     saw_mv, frame_count, last_latency, start_cnt - st);
        end
        net_lat = 10;
        set_scores(7, 8, 9, 1, 2);
        send_frame({IN{16'h0001}}, ok);
        wait_result(n, ok);
        checks++;
        if (!ok || m_class !== 3'd2 || timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL tmo_recover: ok=%0d cls=%0d err=%b want 1 2 1", ok, m_class, timeout_err);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_count !== 16'd3) begin
            fails++;
            $display("FAIL tmo_frame_count: got %0d want 3", frame_count);
        end
    endtask

    task automatic test_backpressure();
        logic [W*NO-1:0] exp_d;
        logic [W*IN-1:0] f;
        bit ok;
        int n, st;
        f = {IN{16'h0055}};
        m_ready = 1'b0;
        net_lat = 6;
        set_scores(1, 2, 3, 4, 5);
        exp_d = net_data;
        st = start_cnt;
        send_frame(f, ok);
        wait_result(n, ok);
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (!ok || m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp_d
                    || m_class !== 3'd4 || net_input_data !== f) begin
                fails++;
                $display("FAIL bp_hold c%0d: mv=%b sr=%b cls=%0d m_data=%h want 1 0 4 %h",
                         c, m_valid, s_ready, m_class, m_data, exp_d);
            end
            s_valid = ~s_valid;
            s_data = {IN{16'(c)}};
            set_scores(c, -c, 0, 9, 1);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (start_cnt - st != 1) begin
            fails++;
            $display("FAIL bp_starts: got %0d want 1", start_cnt - st);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_count !== 16'd4 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: fc=%0d mv=%b sr=%b want 4 0 1", frame_count, m_valid, s_ready);
        end
        s_valid = 1'b1;
        s_data = {IN{16'h0AAA}};
        @(posedge clk); #1;
        s_valid = 1'b0;
        checks++;
        if (net_input_ready !== 1'b1 || net_input_data !== {IN{16'h0AAA}}) begin
            fails++;
            $display("FAIL bp_next_accept: nir=%b nid=%h", net_input_ready, net_input_data);
        end
        wait_result(n, ok);
        @(posedge clk); #1;
        checks++;
        if (!ok || frame_count !== 16'd5) begin
            fails++;
            $display("FAIL bp_second: ok=%0d fc=%0d want 1 5", ok, frame_count);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, saw_mv;
        m_ready = 1'b1;
        net_lat = 5;
        set_scores(3, 1, 4, 1, 5);
        send_frame({IN{16'h0777}}, ok);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({s_ready, net_input_ready, m_valid, busy, timeout_err} !== 5'b10000) begin
            fails++;
            $display("FAIL midrst_ctrl: got %b want 10000", {s_ready, net_input_ready, m_valid, busy, timeout_err});
        end
        checks++;
        if (frame_count !== 16'd0 || last_latency !== 16'd0 || m_class !== 3'd0
                || m_data !== '0 || net_input_data !== '0) begin
            fails++;
            $display("FAIL midrst_regs: fc=%0d lat=%0d cls=%0d want 0", frame_count, last_latency, m_class);
        end
        saw_mv = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (m_valid === 1'b1 || busy === 1'b1) saw_mv = 1'b1;
        end
        checks++;
        if (saw_mv || frame_count !== 16'd0) begin
            fails++;
            $display("FAIL midrst_quiet: activity=%0d fc=%0d want 0 0", saw_mv, frame_count);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n, st, results;
        m_ready = 1'b1;
        net_lat = 3;
        st = start_cnt;
        results = 0;
        for (int fr = 0; fr < 300; fr++) begin
            set_scores($urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4,
                       $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4);
            send_frame({IN{16'(fr)}}, ok);
            wait_result(n, ok);
            if (ok) results++;
            checks++;
            if (!ok || m_class !== CW'(ref_argmax(net_data)) || m_data !== net_data) begin
                fails++;
                $display("FAIL b2b_frame%0d: ok=%0d cls=%0d want %0d", fr, ok, m_class, ref_argmax(net_data));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (frame_count !== 16'd300 || start_cnt - st != 300 || results != 300) begin
            fails++;
            $display("FAIL b2b_totals: fc=%0d starts=%0d results=%0d want 300", frame_count, start_cnt - st, results);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mlp_inference_scheduler.md
Name: mlp_inference_scheduler

Overview:
Sequences single-frame inference through the fixed-point MLP jet-tagging network (dense/ReLU stack plus softmax). Accepts a 16-feature frame on a valid/ready slave port and registers it. Pulses the network start and waits for network done, then lets the softmax output settle and captures the class scores. Computes the winning class with a sequential argmax and presents scores plus class on a valid/ready master port. Reports a timeout error, a frame count and the measured network latency.

Parameters:
WIDTH, 16, fixed-point word width of features and scores
NFRAC, 10, fractional bits (informational only; no scaling performed)
INPUT_SIZE, 16, features per frame
OUTPUT_SIZE, 5, class scores per frame
SOFTMAX_DELAY, 2, cycles from net_done sampled to score capture (softmax register depth)
TIMEOUT, 1024, max cycles waited for net_done before abort
LAT_W, 16, width of latency and frame counters

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
s_valid  in  1  input frame valid
s_ready  out  1  scheduler can accept a frame
s_data  in  WIDTH x INPUT_SIZE  signed input features
net_input_ready  out  1  one-cycle start pulse to network
net_input_data  out  WIDTH x INPUT_SIZE  registered features, held stable from accept until return to IDLE
net_output_ready  in  1  network done (level or pulse)
net_output_data  in  WIDTH x OUTPUT_SIZE  signed softmax scores
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_data  out  WIDTH x OUTPUT_SIZE  captured scores
m_class  out  $clog2(OUTPUT_SIZE)  argmax index
busy  out  1  high whenever state != IDLE
timeout_err  out  1  sticky abort flag; cleared only by reset
frame_count  out  LAT_W  completed frames (m handshakes), wraps
last_latency  out  LAT_W  cycles from start pulse to first net_output_ready of last frame, saturating

Behaviour:
- States: IDLE, LAUNCH, WAIT, SETTLE, ARGMAX, OUT.
- Reset values:
  - State IDLE; s_ready=1; net_input_ready=0; m_valid=0; busy=0; timeout_err=0.
  - All data registers 0; m_class=0; frame_count=0; last_latency=0.
- IDLE:
  - s_ready=1.
  - On s_valid&s_ready, register s_data into net_input_data and go to LAUNCH.
  - s_ready is 0 in every other state. One frame in flight; no buffering.
- LAUNCH (1 cycle):
  - net_input_ready=1. Clear the wait counter. Go to WAIT.
- WAIT:
  - Wait counter increments each cycle.
  - If net_output_ready=1, store the counter value (saturated) in last_latency and go to SETTLE. A done in the LAUNCH cycle is ignored.
  - Otherwise, if the counter reaches TIMEOUT-1, set timeout_err and go to IDLE. No result is produced and frame_count is unchanged.
- Latency definition: done sampled in the first WAIT cycle gives last_latency=1.
- SETTLE:
  - Lasts exactly SOFTMAX_DELAY cycles; SOFTMAX_DELAY=0 skips the state.
  - On exit, capture net_output_data into m_data.
  - net_output_ready is ignored from this point until the next LAUNCH.
- ARGMAX (OUTPUT_SIZE-1 cycles):
  - Start with best=0. Index i=1..OUTPUT_SIZE-1 is compared one per cycle using a signed compare.
  - Replace best only if score[i] > score[best] (strict), so ties resolve to the lowest index.
  - Write m_class at exit. Go to OUT.
- OUT:
  - m_valid=1. m_data and m_class are held stable while m_valid=1 and m_ready=0.
  - On m_ready, increment frame_count (wraps) and go to IDLE. m_valid drops the next cycle.
- Throughput: a new frame can be accepted the cycle after the OUT handshake.
- Accept-to-m_valid latency = 1 (LAUNCH) + WAIT cycles + SOFTMAX_DELAY + OUTPUT_SIZE-1 + 1.
- Reset asserted mid-operation: next cycle is IDLE with all reset values, any in-flight frame discarded, timeout_err cleared.
- s_valid while busy has no effect; upstream must hold s_data until the handshake.

Test Plan:
1. Reset, then s_valid with features 0x0400 x16; network model asserts done 10 cycles after start; scores {100,-50,300,300,20}, SOFTMAX_DELAY=2 -> one start pulse; last_latency=10; m_valid 1+10+2+4+1=18 cycles after accept; m_data equals scores; m_class=2 (tie with index 3, lowest wins); frame_count=1.
2. Scores all negative {-5,-3,-9,-3,-100} -> m_class=1 (signed compare, tie to lowest index).
3. Network never asserts done, TIMEOUT=1024 -> timeout_err=1 1024 cycles after start; state IDLE; s_ready=1; no m_valid; frame_count unchanged; next frame completes normally with timeout_err still 1.
4. Hold m_ready=0 for 7 cycles in OUT; toggle s_valid and change s_data meanwhile -> s_ready=0, outputs stable, no second start pulse; on m_ready=1 frame_count increments by 1; next frame accepted one cycle later.
5. Assert reset during WAIT, with done arriving the same cycle -> next cycle all outputs at reset values; no result or count change.
6. 300 back-to-back frames with m_ready=1 and done latency 3 -> exactly 300 start pulses and 300 results; frame_count=300; each m_class matches the reference argmax.
